// File: rtl/sobel_gradient_stream.sv
// ---------------------------------------------------------------------------
// sobel_gradient_stream
//
// Streaming 3x3 Sobel stage for the Canny edge pipeline. Raster-order pixels
// come in, two line buffers hold the previous two lines, and a signed Gx/Gy
// pair goes out for every interior pixel of the frame (border centres are
// skipped). There is one output register with a valid/ready handshake and a
// latency of one cycle from the accepting edge.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   pix_in     in   unsigned pixel, raster order
//   pix_sof    in   marks pixel (0,0) of a frame (qualified by pix_valid)
//   pix_valid  in   pix_in / pix_sof valid
//   pix_ready  out  stage can accept a pixel this cycle
//   gx, gy     out  signed gradients, PIX_W+3 bits
//   out_last   out  set on the final interior result of a frame
//   out_valid  out  gx / gy / out_last valid
//   out_ready  in   downstream accepts the result this cycle
// ---------------------------------------------------------------------------
module sobel_gradient_stream #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int PIX_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PIX_W-1:0]        pix_in,
    input  logic                    pix_sof,
    input  logic                    pix_valid,
    output logic                    pix_ready,
    output logic signed [PIX_W+2:0] gx,
    output logic signed [PIX_W+2:0] gy,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int GW = PIX_W + 3;
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_HEIGHT - 1);

    // Zero-extend an unsigned pixel into the signed gradient width.
    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] v);
        return $signed({3'b000, v});
    endfunction

    logic [XW-1:0] x_q, x_d, x_cur;
    logic [YW-1:0] y_q, y_d, y_cur;

    // Line buffers: lb_old holds line y-2, lb_new holds line y-1. Not reset;
    // a result needs y>=2, by which point both lines have been rewritten.
    logic [PIX_W-1:0] lb_old [IMG_WIDTH];
    logic [PIX_W-1:0] lb_new [IMG_WIDTH];

    // Only the two older window columns are stored; the newest column is
    // the one arriving this cycle (two line-buffer reads plus pix_in).
    logic [PIX_W-1:0] win_q [3][2];
    logic [PIX_W-1:0] win_d [3][2];
    logic [PIX_W-1:0] col_new [3];

    logic                 in_xfer, emit, last_pix;
    logic signed [GW-1:0] gx_calc, gy_calc;
    logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
    logic                 out_valid_q, out_valid_d, out_last_q, out_last_d;

    assign pix_ready = !out_valid_q || out_ready;
    assign in_xfer   = pix_valid && pix_ready;
    assign gx        = gx_q;
    assign gy        = gy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    always_comb begin
        x_cur = x_q;
        y_cur = y_q;
        if (pix_valid && pix_sof) begin
            x_cur = '0;
            y_cur = '0;
        end
    end

    always_comb begin
        col_new[0] = lb_old[x_cur];
        col_new[1] = lb_new[x_cur];
        col_new[2] = pix_in;
    end

    assign emit     = in_xfer && (x_cur >= XW'(2)) && (y_cur >= YW'(2));
    assign last_pix = (x_cur == X_MAX) && (y_cur == Y_MAX);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (in_xfer) begin
            if (x_cur == X_MAX) begin
                x_d = '0;
                y_d = (y_cur == Y_MAX) ? '0 : y_cur + 1'b1;
            end else begin
                x_d = x_cur + 1'b1;
                y_d = y_cur;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end
        if (in_xfer) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = col_new[r];
            end
        end
    end

    // p[r][0] = win_q[r][0], p[r][1] = win_q[r][1], p[r][2] = col_new[r].
    // Each partial sum tops out at 4*(2^PIX_W-1), which fits GW signed bits.
    always_comb begin
        gx_calc = (ext(col_new[0]) + (ext(col_new[1]) <<< 1) + ext(col_new[2]))
                - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy_calc = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(col_new[2]))
                - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(col_new[0]));
    end

    // emit implies pix_ready, so a held (stalled) result is never overwritten.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        gx_d        = gx_q;
        gy_d        = gy_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_last_d  = last_pix;
            gx_d        = gx_calc;
            gy_d        = gy_calc;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            lb_old[x_cur] <= lb_new[x_cur];
            lb_new[x_cur] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 2; c++) begin
                    win_q[r][c] <= win_d[r][c];
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_gradient_stream.sv
// ---------------------------------------------------------------------------
// tb_sobel_gradient_stream
//
// Drives whole frames into sobel_gradient_stream and compares every
// transferred result against a reference computed directly from the image
// array with the Sobel formulas.
// ---------------------------------------------------------------------------
module tb_sobel_gradient_stream;

    localparam int W  = 64;
    localparam int H  = 64;
    localparam int PW = 8;
    localparam int GW = PW + 3;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic signed [GW-1:0] gx;
        logic signed [GW-1:0] gy;
        logic                 last;
    } res_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [PW-1:0]        pix_in;
    logic                 pix_sof;
    logic                 pix_valid;
    logic                 pix_ready;
    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    res_t          got_q[$];
    res_t          exp_q[$];
    logic [PW-1:0] img [H][W];
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    sobel_gradient_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .gx        (gx),
        .gy        (gy),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // One clock: drive inputs after the falling edge, let them settle, then
    // note what will transfer on the coming rising edge.
    task automatic step(input logic pv, input logic [PW-1:0] pin, input logic sof,
                        input logic ordy, output bit acc);
        res_t r;
        @(negedge clk);
        pix_valid = pv;
        pix_in    = pin;
        pix_sof   = sof;
        out_ready = ordy;
        #1;
        acc = pv && pix_ready;
        if (out_valid && out_ready) begin
            r.gx = gx; r.gy = gy; r.last = out_last;
            got_q.push_back(r);
        end
    endtask

    // mode: 0 flat 100, 1 vertical step, 2 horizontal step, 3 ramp, 4 random
    task automatic fill_img(input int mode);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                case (mode)
                    0:       img[y][x] = 8'd100;
                    1:       img[y][x] = (x < 32) ? 8'd0 : 8'd255;
                    2:       img[y][x] = (y < 32) ? 8'd255 : 8'd0;
                    3:       img[y][x] = 8'(x);
                    default: img[y][x] = 8'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    // Reference: every interior centre in raster order, straight from the
    // image array.
    task automatic build_exp(input bit append);
        res_t e;
        int   p [3][3];
        int   vx, vy;
        if (!append) exp_q.delete();
        for (int cy = 1; cy <= H - 2; cy++) begin
            for (int cx = 1; cx <= W - 2; cx++) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        p[r][c] = int'(img[cy - 1 + r][cx - 1 + c]);
                vx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
                vy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
                e.gx   = GW'(vx);
                e.gy   = GW'(vy);
                e.last = (cx == W - 2) && (cy == H - 2);
                exp_q.push_back(e);
            end
        end
    endtask

    // rdy_mode 0: out_ready always high; 1: out_ready random (~75% high).
    task automatic drive_frame(input int first, input int count, input bit with_sof,
                               input int rdy_mode, output bit ok);
        int   idx = first;
        int   cyc = 0;
        bit   acc;
        logic ordy;
        while (idx < first + count && cyc < count * 10) begin
            ordy = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            step(1'b1, img[idx / W][idx % W], with_sof && (idx == 0), ordy, acc);
            if (acc) idx++;
            cyc++;
        end
        ok = (idx == first + count);
    endtask

    task automatic drain(output bit ok);
        bit acc;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, '0, 1'b0, 1'b1, acc);
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got_q.size()) return i;
            if (got_q[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic int count_last();
        int n = 0;
        foreach (got_q[i]) if (got_q[i].last) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_in = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (gx !== '0) $display("FAIL reset_gx: got %0d want 0", gx); else n_pass++;
        n_checks++; if (gy !== '0) $display("FAIL reset_gy: got %0d want 0", gy); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %0b want 0", out_last); else n_pass++;
        n_checks++; if (pix_ready !== 1'b1) $display("FAIL reset_pix_ready: got %0b want 1", pix_ready); else n_pass++;
    endtask

    // Full frame with out_ready held high, checked against the reference.
    task automatic test_pattern(input int mode, input string name);
        bit ok_d, ok_n;
        int d;
        fill_img(mode);
        build_exp(1'b0);
        got_q.delete();
        drive_frame(0, NPIX, 1'b1, 0, ok_d);
        drain(ok_n);
        n_checks++; if (!(ok_d && ok_n)) $display("FAIL %s_progress: accepted_all=%0b drained=%0b want 1/1", name, ok_d, ok_n); else n_pass++;
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL %s_count: got %0d results want %0d", name, got_q.size(), exp_q.size()); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d >= 0) $display("FAIL %s_data: result %0d got gx=%0d gy=%0d last=%0b want gx=%0d gy=%0d last=%0b",
                             name, d, got_q[d].gx, got_q[d].gy, got_q[d].last, exp_q[d].gx, exp_q[d].gy, exp_q[d].last);
        else n_pass++;
        if (mode == 0) begin
            n_checks++; if (count_last() !== 1) $display("FAIL %s_last_count: got %0d want 1", name, count_last()); else n_pass++;
        end
    endtask

    task automatic test_random_stall();
        bit ok_d, ok_n;
        int d;
        fill_img(4);
        build_exp(1'b0);
        got_q.delete();
        drive_frame(0, NPIX, 1'b1, 1, ok_d);
        drain(ok_n);
        n_checks++; if (!(ok_d && ok_n)) $display("FAIL rstall_progress: accepted_all=%0b drained=%0b want 1/1", ok_d, ok_n); else n_pass++;
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rstall_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d >= 0) $display("FAIL rstall_data: result %0d got gx=%0d gy=%0d last=%0b want gx=%0d gy=%0d last=%0b",
                             d, got_q[d].gx, got_q[d].gy, got_q[d].last, exp_q[d].gx, exp_q[d].gy, exp_q[d].last);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit   ok_a, ok_b, ok_n, acc;
        int   d;
        logic signed [GW-1:0] hgx, hgy;
        logic hlast;
        fill_img(4);
        build_exp(1'b0);
        got_q.delete();
        drive_frame(0, 2000, 1'b1, 0, ok_a);
        for (int s = 0; s < 5; s++) begin
            step(1'b1, img[2000 / W][2000 % W], 1'b0, 1'b0, acc);
            n_checks++; if (pix_ready !== 1'b0) $display("FAIL bp_pix_ready: cycle %0d got %0b want 0", s, pix_ready); else n_pass++;
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: cycle %0d got %0b want 1", s, out_valid); else n_pass++;
            if (s == 0) begin
                hgx = gx; hgy = gy; hlast = out_last;
            end else begin
                n_checks++;
                if (gx !== hgx || gy !== hgy || out_last !== hlast)
                    $display("FAIL bp_hold: cycle %0d got gx=%0d gy=%0d last=%0b want gx=%0d gy=%0d last=%0b", s, gx, gy, out_last, hgx, hgy, hlast);
                else n_pass++;
            end
        end
        drive_frame(2000, NPIX - 2000, 1'b0, 0, ok_b);
        drain(ok_n);
        n_checks++; if (!(ok_a && ok_b && ok_n)) $display("FAIL bp_progress: %0b%0b%0b want 111", ok_a, ok_b, ok_n); else n_pass++;
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL bp_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d >= 0) $display("FAIL bp_data: result %0d got gx=%0d gy=%0d last=%0b want gx=%0d gy=%0d last=%0b",
                             d, got_q[d].gx, got_q[d].gy, got_q[d].last, exp_q[d].gx, exp_q[d].gy, exp_q[d].last);
        else n_pass++;
    endtask

    // Two frames with no gap; the second has no sof so the counters must wrap.
    task automatic test_back_to_back();
        bit ok_a, ok_b, ok_n;
        int d;
        got_q.delete();
        fill_img(4);
        build_exp(1'b0);
        drive_frame(0, NPIX, 1'b1, 0, ok_a);
        fill_img(4);
        build_exp(1'b1);
        drive_frame(0, NPIX, 1'b0, 0, ok_b);
        drain(ok_n);
        n_checks++; if (!(ok_a && ok_b && ok_n)) $display("FAIL b2b_progress: %0b%0b%0b want 111", ok_a, ok_b, ok_n); else n_pass++;
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d >= 0) $display("FAIL b2b_data: result %0d got gx=%0d gy=%0d last=%0b want gx=%0d gy=%0d last=%0b",
                             d, got_q[d].gx, got_q[d].gy, got_q[d].last, exp_q[d].gx, exp_q[d].gy, exp_q[d].last);
        else n_pass++;
    endtask

    // Abandon a frame part-way with a fresh sof (no reset).
    task automatic test_sof_resync();
        bit ok_a, ok_b, ok_n;
        int d;
        fill_img(4);
        drive_frame(0, 130, 1'b1, 0, ok_a);
        got_q.delete();
        fill_img(4);
        build_exp(1'b0);
        drive_frame(0, NPIX, 1'b1, 0, ok_b);
        drain(ok_n);
        n_checks++; if (!(ok_a && ok_b && ok_n)) $display("FAIL sof_progress: %0b%0b%0b want 111", ok_a, ok_b, ok_n); else n_pass++;
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL sof_count: got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d >= 0) $display("FAIL sof_data: result %0d got gx=%0d gy=%0d last=%0b want gx=%0d gy=%0d last=%0b",
                             d, got_q[d].gx, got_q[d].gy, got_q[d].last, exp_q[d].gx, exp_q[d].gy, exp_q[d].last);
        else n_pass++;
    endtask

    // Reset with a result pending, then a full frame (mode 0 with sof, or a
    // random frame without sof to show the counters restart at (0,0)).
    task automatic test_reset_mid(input int mode, input bit use_sof, input string name);
        bit ok_a, ok_b, ok_n, acc;
        int d;
        fill_img(0);
        drive_frame(0, 150, 1'b1, 0, ok_a);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        n_checks++; if (out_valid !== 1'b1) $display("FAIL %s_pending: out_valid got %0b want 1", name, out_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b1; pix_valid = 1'b1; pix_in = 8'd7; pix_sof = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0; pix_valid = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || gx !== '0 || gy !== '0 || out_last !== 1'b0)
            $display("FAIL %s_after_rst: got valid=%0b gx=%0d gy=%0d last=%0b want 0/0/0/0", name, out_valid, gx, gy, out_last);
        else n_pass++;
        got_q.delete();
        fill_img(mode);
        build_exp(1'b0);
        drive_frame(0, NPIX, use_sof, 0, ok_b);
        drain(ok_n);
        n_checks++; if (!(ok_a && ok_b && ok_n)) $display("FAIL %s_progress: %0b%0b%0b want 111", name, ok_a, ok_b, ok_n); else n_pass++;
        n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL %s_count: got %0d want %0d", name, got_q.size(), exp_q.size()); else n_pass++;
        d = first_diff();
        n_checks++;
        if (d >= 0) $display("FAIL %s_data: result %0d got gx=%0d gy=%0d last=%0b want gx=%0d gy=%0d last=%0b",
                             name, d, got_q[d].gx, got_q[d].gy, got_q[d].last, exp_q[d].gx, exp_q[d].gy, exp_q[d].last);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_pattern(0, "flat");
        test_pattern(1, "vstep");
        test_pattern(2, "hstep");
        test_pattern(3, "ramp");
        test_pattern(4, "random");
        test_random_stall();
        test_backpressure();
        test_back_to_back();
        test_sof_resync();
        test_reset_mid(0, 1'b1, "rstmid_flat");
        test_reset_mid(4, 1'b0, "rstmid_rand");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
